// File: rtl/coherency_ctrl_pkg.sv
// Shared types and constants for the Cohort coherency watch/backoff path.
package coherency_ctrl_pkg;

  localparam int unsigned cache_line_num   = 4;
  localparam int unsigned backoff_width    = 16;
  localparam int unsigned addr_width       = 32;
  localparam int unsigned line_offset_bits = 6;
  // Wide enough to carry out-of-range sizes (up to 7) so they can be clamped.
  localparam int unsigned size_width       = $clog2(cache_line_num) + 1;

  typedef logic [addr_width-1:0]     addr_t;
  typedef logic [size_width-1:0]     size_t;
  typedef logic [backoff_width-1:0]  backoff_t;
  typedef logic [cache_line_num-1:0] line_mask_t;
  typedef addr_t [cache_line_num-1:0] addr_arr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    BACKOFF = 2'd2,
    NOTIFY  = 2'd3
  } watch_state_e;

  // Sizes above the entry count arm every entry.
  function automatic size_t clamp_size(input size_t size);
    return (size > size_t'(cache_line_num)) ? size_t'(cache_line_num) : size;
  endfunction

  // Same cache line when only the in-line offset bits differ.
  function automatic logic line_match(input addr_t a, input addr_t b);
    return ((a ^ b) >> line_offset_bits) == '0;
  endfunction

endpackage

// File: rtl/coherency_watch_backoff_if.sv
// Bus bundle between the coherency controller / snoop source and the watch block.
interface coherency_watch_backoff_if;
  import coherency_ctrl_pkg::*;

  logic       cfg_valid_i;
  logic       cfg_ready_o;
  size_t      cfg_size_i;
  addr_arr_t  cfg_addr_i;
  backoff_t   cfg_backoff_i;
  logic       inv_valid_i;
  addr_t      inv_addr_i;
  logic       disarm_i;
  logic       notify_valid_o;
  logic       notify_ready_i;
  line_mask_t notify_mask_o;
  logic       busy_o;

  // Controller / snoop / consumer side.
  modport master (
    output cfg_valid_i, cfg_size_i, cfg_addr_i, cfg_backoff_i,
    output inv_valid_i, inv_addr_i, disarm_i, notify_ready_i,
    input  cfg_ready_o, notify_valid_o, notify_mask_o, busy_o
  );

  // Watch block side.
  modport slave (
    input  cfg_valid_i, cfg_size_i, cfg_addr_i, cfg_backoff_i,
    input  inv_valid_i, inv_addr_i, disarm_i, notify_ready_i,
    output cfg_ready_o, notify_valid_o, notify_mask_o, busy_o
  );

endinterface

// File: rtl/coherency_backoff_cnt.sv
// Saturating backoff down-counter; expire flags the last backoff cycle
// (or a zero-length backoff at load time).
module coherency_backoff_cnt
  import coherency_ctrl_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     load,
  input  backoff_t load_value,
  input  logic     enable,
  input  logic     clear,
  output logic     expire
);

  backoff_t count_reg;

  // Clear has priority, then load, then a decrement that stops at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - backoff_t'(1);
    end
  end

  assign expire = load ? (load_value == '0) : (count_reg == backoff_t'(1));

endmodule

// File: rtl/coherency_watch_backoff.sv
// Watches a batch of cache lines against the invalidation stream and, after a
// backoff from the first hit, raises one notification with the hit mask.
module coherency_watch_backoff
  import coherency_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  coherency_watch_backoff_if.slave bus
);

  watch_state_e state_reg;
  line_mask_t   valid_reg;
  addr_arr_t    addr_reg;
  backoff_t     backoff_reg;
  line_mask_t   mask_reg;
  logic         notify_valid_reg;
  line_mask_t   notify_mask_reg;

  line_mask_t   hit;
  line_mask_t   cfg_valid_bits;
  size_t        cfg_size_eff;
  logic         disarm_act;
  logic         cnt_load;
  logic         cnt_enable;
  logic         cnt_clear;
  logic         cnt_expire;

  assign cfg_size_eff = clamp_size(bus.cfg_size_i);

  // Per-entry line compare and the valid bits a new batch would arm.
  for (genvar gi = 0; gi < int'(cache_line_num); gi++) begin : g_entry
    assign hit[gi] = valid_reg[gi] && bus.inv_valid_i
                     && line_match(addr_reg[gi], bus.inv_addr_i);
    assign cfg_valid_bits[gi] = size_t'(gi) < cfg_size_eff;
  end

  assign disarm_act = bus.disarm_i && ((state_reg == ARMED) || (state_reg == BACKOFF));
  assign cnt_load   = (state_reg == ARMED) && (|hit) && !bus.disarm_i;
  assign cnt_enable = (state_reg == BACKOFF) && !bus.disarm_i;
  assign cnt_clear  = disarm_act || ((state_reg == NOTIFY) && bus.notify_ready_i);

  coherency_backoff_cnt u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load       (cnt_load),
    .load_value (backoff_reg),
    .enable     (cnt_enable),
    .clear      (cnt_clear),
    .expire     (cnt_expire)
  );

  // Watch FSM: arm on config, accumulate hits through backoff, hold notification.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      valid_reg        <= '0;
      addr_reg         <= '0;
      backoff_reg      <= '0;
      mask_reg         <= '0;
      notify_valid_reg <= 1'b0;
      notify_mask_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A zero-sized batch is accepted but arms nothing.
          if (bus.cfg_valid_i && (bus.cfg_size_i != '0)) begin
            addr_reg    <= bus.cfg_addr_i;
            backoff_reg <= bus.cfg_backoff_i;
            valid_reg   <= cfg_valid_bits;
            mask_reg    <= '0;
            state_reg   <= ARMED;
          end
        end
        ARMED: begin
          if (bus.disarm_i) begin
            valid_reg <= '0;
            mask_reg  <= '0;
            state_reg <= IDLE;
          end else if (|hit) begin
            mask_reg <= mask_reg | hit;
            if (cnt_expire) begin
              notify_valid_reg <= 1'b1;
              notify_mask_reg  <= mask_reg | hit;
              state_reg        <= NOTIFY;
            end else begin
              state_reg <= BACKOFF;
            end
          end
        end
        BACKOFF: begin
          if (bus.disarm_i) begin
            valid_reg <= '0;
            mask_reg  <= '0;
            state_reg <= IDLE;
          end else begin
            mask_reg <= mask_reg | hit;
            // Hits arriving in the final backoff cycle still make the mask.
            if (cnt_expire) begin
              notify_valid_reg <= 1'b1;
              notify_mask_reg  <= mask_reg | hit;
              state_reg        <= NOTIFY;
            end
          end
        end
        NOTIFY: begin
          if (bus.notify_ready_i) begin
            notify_valid_reg <= 1'b0;
            notify_mask_reg  <= '0;
            valid_reg        <= '0;
            mask_reg         <= '0;
            state_reg        <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready_o    = (state_reg == IDLE);
  assign bus.busy_o         = (state_reg != IDLE);
  assign bus.notify_valid_o = notify_valid_reg;
  assign bus.notify_mask_o  = notify_mask_reg;

endmodule

// File: tb/tb_coherency_watch_backoff.sv
// Directed bench for coherency_watch_backoff with hand-computed expectations.
module tb_coherency_watch_backoff;
  import coherency_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  coherency_watch_backoff_if bus();

  coherency_watch_backoff dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int size, input addr_t a0, input addr_t a1,
                           input addr_t a2, input addr_t a3, input backoff_t bo);
    bus.cfg_valid_i   = 1'b1;
    bus.cfg_size_i    = size_t'(size);
    bus.cfg_addr_i[0] = a0;
    bus.cfg_addr_i[1] = a1;
    bus.cfg_addr_i[2] = a2;
    bus.cfg_addr_i[3] = a3;
    bus.cfg_backoff_i = bo;
    tick();
    bus.cfg_valid_i   = 1'b0;
  endtask

  task automatic snoop(input addr_t a);
    bus.inv_valid_i = 1'b1;
    bus.inv_addr_i  = a;
    tick();
    bus.inv_valid_i = 1'b0;
    bus.inv_addr_i  = '0;
  endtask

  task automatic check_notify(input string tag, input logic v, input logic [3:0] m);
    check_val({tag, "_valid"}, 32'(bus.notify_valid_o), 32'(v));
    check_val({tag, "_mask"},  32'(bus.notify_mask_o),  32'(m));
  endtask

  task automatic check_idle(input string tag);
    check_notify(tag, 1'b0, 4'b0000);
    check_val({tag, "_busy"},  32'(bus.busy_o),      32'd0);
    check_val({tag, "_ready"}, 32'(bus.cfg_ready_o), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.cfg_valid_i    = 1'b0;
    bus.cfg_size_i     = '0;
    bus.cfg_addr_i     = '0;
    bus.cfg_backoff_i  = '0;
    bus.inv_valid_i    = 1'b0;
    bus.inv_addr_i     = '0;
    bus.disarm_i       = 1'b0;
    bus.notify_ready_i = 1'b0;

    // Reset values
    #12;
    check_idle("rst");
    rst_n = 1'b1;
    tick();

    // Basic: backoff 3, neighbouring line 0x2080 must not match 0x2040
    configure(2, 32'h1000, 32'h2040, 32'h0, 32'h0, 16'd3);
    check_val("basic_busy", 32'(bus.busy_o), 32'd1);
    check_val("basic_cfg_ready", 32'(bus.cfg_ready_o), 32'd0);
    snoop(32'h2080);
    check_notify("basic_nohit", 1'b0, 4'b0000);
    snoop(32'h1010);
    check_notify("basic_t1", 1'b0, 4'b0000);
    tick();
    check_notify("basic_t2", 1'b0, 4'b0000);
    tick();
    check_notify("basic_t3", 1'b0, 4'b0000);
    tick();
    check_notify("basic_t4", 1'b1, 4'b0001);
    tick();
    tick();
    check_notify("basic_hold", 1'b1, 4'b0001);
    bus.notify_ready_i = 1'b1;
    tick();
    bus.notify_ready_i = 1'b0;
    check_idle("basic_done");

    // Accumulate hits on entries 1, 3, 0 through a backoff of 4
    configure(4, 32'h100, 32'h200, 32'h300, 32'h400, 16'd4);
    snoop(32'h208);
    tick();
    snoop(32'h400);
    tick();
    check_notify("acc_pre", 1'b0, 4'b0000);
    snoop(32'h100);
    check_notify("acc_t5", 1'b1, 4'b1011);
    snoop(32'h300);
    check_notify("acc_notify_drop", 1'b1, 4'b1011);
    bus.notify_ready_i = 1'b1;
    tick();
    bus.notify_ready_i = 1'b0;
    check_idle("acc_done");

    // Zero backoff, ready tied high
    bus.notify_ready_i = 1'b1;
    configure(1, 32'h3000, 32'h0, 32'h0, 32'h0, 16'd0);
    snoop(32'h3000);
    check_notify("bo0", 1'b1, 4'b0001);
    tick();
    check_idle("bo0_done");
    bus.notify_ready_i = 1'b0;

    // Zero-sized batch stays idle
    configure(0, 32'h100, 32'h200, 32'h300, 32'h400, 16'd1);
    check_idle("size0");
    snoop(32'h100);
    check_idle("size0_snoop");

    // Size 7 clamps to 4; hit in the expiry cycle is captured
    configure(7, 32'h100, 32'h200, 32'h300, 32'h400, 16'd1);
    check_val("clamp_busy", 32'(bus.busy_o), 32'd1);
    snoop(32'h400);
    check_notify("clamp_t1", 1'b0, 4'b0000);
    snoop(32'h100);
    check_notify("clamp_t2", 1'b1, 4'b1001);
    bus.notify_ready_i = 1'b1;
    tick();
    bus.notify_ready_i = 1'b0;
    check_idle("clamp_done");

    // Disarm in the counter==1 cycle wins
    configure(1, 32'h500, 32'h0, 32'h0, 32'h0, 16'd2);
    snoop(32'h500);
    tick();
    bus.disarm_i = 1'b1;
    tick();
    bus.disarm_i = 1'b0;
    check_idle("disarm_exp");
    tick();
    check_idle("disarm_after");

    // Disarm ignored during NOTIFY
    configure(1, 32'h600, 32'h0, 32'h0, 32'h0, 16'd0);
    snoop(32'h600);
    bus.disarm_i = 1'b1;
    tick();
    check_notify("disarm_notify", 1'b1, 4'b0001);
    check_val("disarm_notify_busy", 32'(bus.busy_o), 32'd1);
    bus.notify_ready_i = 1'b1;
    tick();
    bus.disarm_i = 1'b0;
    bus.notify_ready_i = 1'b0;
    check_idle("disarm_notify_done");

    // Back-to-back: cfg held from the handshake cycle is taken one cycle later
    configure(1, 32'h700, 32'h0, 32'h0, 32'h0, 16'd0);
    snoop(32'h700);
    check_notify("b2b_a", 1'b1, 4'b0001);
    bus.notify_ready_i = 1'b1;
    bus.cfg_valid_i    = 1'b1;
    bus.cfg_size_i     = size_t'(2);
    bus.cfg_addr_i[0]  = 32'h800;
    bus.cfg_addr_i[1]  = 32'h900;
    bus.cfg_backoff_i  = 16'd0;
    tick();
    check_idle("b2b_hs");
    bus.notify_ready_i = 1'b0;
    tick();
    bus.cfg_valid_i = 1'b0;
    check_val("b2b_accept_busy", 32'(bus.busy_o), 32'd1);
    snoop(32'h900);
    check_notify("b2b_b", 1'b1, 4'b0010);
    bus.notify_ready_i = 1'b1;
    tick();
    bus.notify_ready_i = 1'b0;
    check_idle("b2b_done");

    // Asynchronous reset mid-backoff with counter at 5
    configure(1, 32'hA00, 32'h0, 32'h0, 32'h0, 16'd8);
    snoop(32'hA00);
    tick();
    tick();
    tick();
    check_val("arst_pre_busy", 32'(bus.busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst_async");
    #2;
    rst_n = 1'b1;
    tick();
    check_idle("arst_release");
    snoop(32'hA00);
    check_idle("arst_entries_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coherency_watch_backoff.md
Name: coherency_watch_backoff

Overview:
Receives a batch of physical cache-line addresses to watch from the Cohort coherency controller. It snoops the invalidation stream and, on the first hit, waits a programmable backoff delay. It then raises a single notification carrying the mask of all lines hit. It sits downstream of the controller's batch/backoff configuration (size_t, addr_t, backoff_t) and upstream of the consumer/producer wake-up logic.

Parameters:
CACHE_LINE_NUM, coherency_ctrl_pkg::cache_line_num (4), number of watch entries
BACKOFF_WIDTH, coherency_ctrl_pkg::backoff_width (16), backoff counter width
LINE_OFFSET_BITS, 6, low address bits ignored in line-match compare

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
cfg_valid_i  in  1  batch configuration valid
cfg_ready_o  out  1  batch accepted when valid&ready
cfg_size_i  in  size_t  number of lines to watch, valid range 0..CACHE_LINE_NUM
cfg_addr_i  in  CACHE_LINE_NUM x addr_t  watch addresses; entry i used if i < size
cfg_backoff_i  in  backoff_t  backoff cycles after first hit
inv_valid_i  in  1  invalidation snoop valid; no backpressure
inv_addr_i  in  addr_t  invalidated address
disarm_i  in  1  cancel the armed batch
notify_valid_o  out  1  notification valid
notify_ready_i  in  1  notification consumed
notify_mask_o  out  CACHE_LINE_NUM  entries hit since arming
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync-released): state IDLE, entry valid bits 0, hit mask 0, counter 0. notify_valid_o=0, notify_mask_o=0, busy_o=0, cfg_ready_o=1.
- Match: entry i hits when valid[i] and inv_valid_i and addr[i][ADDR_MSB:LINE_OFFSET_BITS] == inv_addr_i[ADDR_MSB:LINE_OFFSET_BITS]. Multiple entries may hit in one cycle.
- FSM states: IDLE, ARMED, BACKOFF, NOTIFY.
- IDLE: cfg_ready_o=1 (combinational from state only). On cfg_valid_i:
  - size==0: accept and stay IDLE.
  - size>CACHE_LINE_NUM: clamp to CACHE_LINE_NUM.
  - Otherwise latch addresses and backoff, set valid[0..size-1], clear mask, go to ARMED.
  - Snoops in IDLE are ignored, including the config cycle itself.
- ARMED: cfg_ready_o=0.
  - Any hit: OR hits into mask and load counter=backoff.
  - backoff==0: go to NOTIFY; otherwise go to BACKOFF.
- BACKOFF: decrement counter each cycle and keep ORing new hits into mask.
  - counter==1: go to NOTIFY (hits in that cycle still captured).
- Latency: a hit sampled at edge T gives notify_valid_o high from cycle T+1+backoff.
  - Counter never wraps; it saturates at 0.
  - backoff=2^BACKOFF_WIDTH-1 is legal.
- NOTIFY: notify_valid_o=1 and notify_mask_o=mask; both held stable until notify_ready_i.
  - Hits are dropped while in NOTIFY.
  - On valid&ready: clear valid bits and mask, go to IDLE.
  - notify_ready_i may be tied high.
  - A new cfg is not accepted in the handshake cycle; it is accepted the next cycle.
- disarm_i:
  - In ARMED/BACKOFF: go to IDLE next cycle, clear entries/mask/counter, no notification. Disarm wins over a same-cycle hit or counter expiry.
  - Ignored in IDLE and NOTIFY (a started notification must complete).
- notify_mask_o is 0 whenever notify_valid_o=0.

Decomposition:
- Add to coherency_ctrl_pkg:
  - watch_state_e enum (IDLE, ARMED, BACKOFF, NOTIFY)
  - line_mask_t = logic [cache_line_num-1:0]
  - line_offset_bits constant
  - addr_arr_t = addr_t [cache_line_num-1:0]
- Sub-module coherency_backoff_cnt: load/enable/clear, saturating down-counter of backoff_t, outputs expire when counter==1 or load value==0.
- Top module holds FSM, watch entries and match compare.

Test Plan:
- Reset: rst_ni low mid-BACKOFF, counter=5 -> outputs return to reset values asynchronously; cfg_ready_o=1 after release.
- Basic: size=2, addr={0x1000,0x2040}, backoff=3; inv 0x1010 at edge T -> notify_valid_o rises at T+4 with mask=4'b0001; ready after 2 cycles -> IDLE, busy_o=0.
- Accumulate: size=4, backoff=4; hit entry1 at T, entry3 at T+2, entry0 at T+4 -> mask=4'b1011 at T+5. Hit on entry2 during NOTIFY -> mask unchanged.
- Boundaries:
  - backoff=0 -> notify at T+1.
  - size=0 -> stays IDLE, busy_o=0.
  - size=7 -> clamped, all 4 entries armed.
  - Address 0x2080 vs watch 0x2040 with LINE_OFFSET_BITS=6 -> no hit.
- Disarm: disarm_i in same cycle as counter==1 -> no notify_valid_o, IDLE next cycle. disarm_i during NOTIFY -> ignored, handshake completes.
- Back-to-back: notify handshake at cycle N, cfg_valid_i held from N -> accepted at N+1; second batch notifies with only its own hits.
